// File: rtl/db_pkg.sv
// db_pkg: shared constants, state encodings and FSM type for the flow-state table controller
package db_pkg;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_GET = 1'b0;
  localparam int ST_W = 2;
  typedef logic [ST_W-1:0] st_t;
  localparam st_t ST_IDLE    = 2'b00;
  localparam st_t ST_SUSPECT = 2'b01;
  localparam st_t ST_ARREST  = 2'b10;
  localparam st_t ST_EXPIRE  = 2'b11;
  typedef enum logic [2:0] {F_INIT, F_IDLE, F_READ, F_CMP, F_WRITE} fsm_e;
endpackage

// File: rtl/db_way_ram.sv
// db_way_ram: one way of the table, single-port RAM with registered write-first read
//   clk, we, addr[AW], wdata[DW] in; rdata[DW] out (valid the cycle after addr)
module db_way_ram #(
  parameter int AW = 10,
  parameter int DW = 115
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= we ? wdata : mem[addr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/db_cont_nway.sv
// db_cont_nway: WAYS-way set-associative key/state table with timestamp expiry and escalation
//   in:  clk, rst, tick, in_valid, in_op[3:0], in_hash[HASH_SIZE], in_key[KEY_SIZE]
//   out: in_ready, out_valid, out_hit, out_expired, out_state[1:0], out_evict, busy_init
module db_cont_nway
  import db_pkg::*;
#(
  parameter int HASH_SIZE = 32,
  parameter int KEY_SIZE  = 96,
  parameter int RAM_ADDR  = 10,
  parameter int WAYS      = 4,
  parameter int TS_W      = 16,
  parameter int TTL       = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [HASH_SIZE-1:0] in_hash,
  input  logic [KEY_SIZE-1:0]  in_key,
  output logic                 out_valid,
  output logic                 out_hit,
  output logic                 out_expired,
  output logic [1:0]           out_state,
  output logic                 out_evict,
  output logic                 busy_init
);
  localparam int WAY_W = WAYS > 1 ? $clog2(WAYS) : 1;
  localparam int DW = 1 + ST_W + TS_W + KEY_SIZE;
  localparam logic [TS_W-1:0] TTL_V = TS_W'(TTL);
  fsm_e fsm_q, fsm_d;
  logic [RAM_ADDR-1:0] init_q, init_d, set_q, set_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [2:0] op_q, op_d;
  logic [KEY_SIZE-1:0] key_q, key_d;
  logic [WAY_W-1:0] wr_way_q, wr_way_d;
  logic [DW-1:0] wr_q, wr_d;
  logic ov_q, ov_d, hit_q, hit_d, exp_q, exp_d, ev_q, ev_d;
  st_t st_q, st_d;
  logic [DW-1:0] rd [WAYS];
  logic [WAYS-1:0] v, m, x, we;
  logic [TS_W-1:0] age [WAYS];
  st_t s [WAYS];
  logic [RAM_ADDR-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic hit, inv, anyx, evict;
  logic [WAY_W-1:0] hw, iw, xw, ow, vw;
  st_t req, upd, res;
  logic unused_bits;
  assign unused_bits = ^{in_op[3], in_hash[HASH_SIZE-1:RAM_ADDR]};
  assign ram_addr = fsm_q == F_INIT ? init_q : set_q;
  assign ram_wdata = fsm_q == F_INIT ? '0 : wr_q;
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    assign we[g] = ~rst & (fsm_q == F_INIT | (fsm_q == F_WRITE & wr_way_q == WAY_W'(g)));
    assign v[g] = rd[g][DW-1];
    assign s[g] = rd[g][DW-2 -: ST_W];
    // modular subtraction gives the correct age across counter wrap
    assign age[g] = ts_q - rd[g][KEY_SIZE +: TS_W];
    assign x[g] = age[g] >= TTL_V;
    assign m[g] = v[g] & (rd[g][KEY_SIZE-1:0] == key_q);
    db_way_ram #(.AW(RAM_ADDR), .DW(DW)) u_ram (
      .clk(clk), .we(we[g]), .addr(ram_addr), .wdata(ram_wdata), .rdata(rd[g])
    );
  end
  always_comb begin
    hit = 1'b0;
    inv = 1'b0;
    anyx = 1'b0;
    hw = '0;
    iw = '0;
    xw = '0;
    ow = '0;
    // descending scan so the lowest matching index wins
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (m[w]) begin hit = 1'b1; hw = WAY_W'(w); end
      if (!v[w]) begin inv = 1'b1; iw = WAY_W'(w); end
      if (v[w] & x[w]) begin anyx = 1'b1; xw = WAY_W'(w); end
    end
    // strict compare keeps the lowest index on equal ages
    for (int w = 1; w < WAYS; w++)
      if (age[w] > age[ow]) ow = WAY_W'(w);
  end
  assign evict = ~inv & ~anyx;
  assign vw = inv ? iw : anyx ? xw : ow;
  assign req = op_q[2:1];
  // max() already keeps ARREST against lower requests and lets EXPIRE win
  assign upd = x[hw] ? req : (req > s[hw] ? req : s[hw]);
  assign res = op_q[0] == OP_SET ? (hit ? upd : req) : (hit ? s[hw] : ST_IDLE);
  always_comb begin
    fsm_d = fsm_q;
    init_d = init_q;
    set_d = set_q;
    op_d = op_q;
    key_d = key_q;
    wr_way_d = wr_way_q;
    wr_d = wr_q;
    hit_d = hit_q;
    exp_d = exp_q;
    ev_d = ev_q;
    st_d = st_q;
    ov_d = 1'b0;
    ts_d = ts_q + TS_W'(tick);
    case (fsm_q)
      F_INIT: begin
        init_d = init_q + 1'b1;
        if (&init_q) fsm_d = F_IDLE;
      end
      F_IDLE: if (in_valid) begin
        fsm_d = F_READ;
        op_d = in_op[2:0];
        key_d = in_key;
        set_d = in_hash[RAM_ADDR-1:0];
      end
      F_READ: fsm_d = F_CMP;
      F_CMP: begin
        ov_d = 1'b1;
        hit_d = hit & ~x[hw];
        exp_d = hit & x[hw];
        ev_d = op_q[0] == OP_SET & ~hit & evict;
        st_d = res;
        fsm_d = op_q[0] == OP_SET ? F_WRITE : F_IDLE;
        wr_way_d = hit ? hw : vw;
        wr_d = {1'b1, res, ts_q, key_q};
      end
      F_WRITE: fsm_d = F_IDLE;
      default: fsm_d = F_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= F_INIT;
      init_q <= '0;
      set_q <= '0;
      ts_q <= '0;
      op_q <= '0;
      key_q <= '0;
      wr_way_q <= '0;
      wr_q <= '0;
      ov_q <= 1'b0;
      hit_q <= 1'b0;
      exp_q <= 1'b0;
      ev_q <= 1'b0;
      st_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
      init_q <= init_d;
      set_q <= set_d;
      ts_q <= ts_d;
      op_q <= op_d;
      key_q <= key_d;
      wr_way_q <= wr_way_d;
      wr_q <= wr_d;
      ov_q <= ov_d;
      hit_q <= hit_d;
      exp_q <= exp_d;
      ev_q <= ev_d;
      st_q <= st_d;
    end
  end
  // a reset landing on the result cycle suppresses the strobe
  assign out_valid = ov_q & ~rst;
  assign out_hit = hit_q;
  assign out_expired = exp_q;
  assign out_state = st_q;
  assign out_evict = ev_q;
  assign busy_init = rst | fsm_q == F_INIT;
  assign in_ready = ~rst & fsm_q == F_IDLE;
endmodule

// File: tb/tb_db_cont_nway.sv
// tb_db_cont_nway: randomized and directed checks of db_cont_nway against a table model
module tb_db_cont_nway;
  logic clk = 0, rst = 1, tick = 0, in_valid = 0;
  logic [3:0] in_op = '0;
  logic [31:0] in_hash = '0;
  logic [95:0] in_key = '0;
  logic in_ready, out_valid, out_hit, out_expired, out_evict, busy_init;
  logic [1:0] out_state;
  int checks = 0, failures = 0;
  logic [15:0] ts_m;
  bit mv [1024][4];
  logic [95:0] mk [1024][4];
  logic [1:0] ms [1024][4];
  logic [15:0] mt [1024][4];
  db_cont_nway dut (
    .clk(clk), .rst(rst), .tick(tick), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_hash(in_hash), .in_key(in_key), .out_valid(out_valid),
    .out_hit(out_hit), .out_expired(out_expired), .out_state(out_state),
    .out_evict(out_evict), .busy_init(busy_init)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst) ts_m <= 16'd0; else if (tick) ts_m <= ts_m + 16'd1;
  task automatic clear_model();
    for (int s = 0; s < 1024; s++) for (int w = 0; w < 4; w++) mv[s][w] = 0;
  endtask
  task automatic advance(input int n);
    for (int i = 0; i < n; i++) begin tick = 1; @(negedge clk); end
    tick = 0;
  endtask
  task automatic flush_wait(output int n);
    n = 0;
    while (busy_init && n < 2000) begin
      checks++;
      if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0 cycle=%0d", in_ready, n); end
      n++;
      @(negedge clk);
    end
  endtask
  task automatic req(input bit set, input logic [1:0] st, input logic [31:0] hash,
                     input logic [95:0] key, input bit rt, output logic [4:0] obs);
    int n, si, hw, vic, best;
    logic [15:0] ts_s, a;
    logic [4:0] e;
    bit expd;
    in_valid = 1;
    in_op = {1'($urandom), set ? st : 2'($urandom), set};
    in_hash = hash;
    in_key = key;
    n = 0;
    while (!in_ready && n < 2000) begin tick = 0; @(negedge clk); n++; end
    checks++;
    if (!in_ready) begin
      failures++; $display("FAIL accept_timeout got=%b want=1", in_ready);
      in_valid = 0; obs = 'x; return;
    end
    tick = rt ? 1'($urandom) : 1'b0;
    @(negedge clk);
    in_valid = 0;
    in_op = 4'($urandom);
    in_key = 96'($urandom);
    tick = rt ? 1'($urandom) : 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL early_valid_read got=%b want=0", out_valid); end
    @(negedge clk);
    ts_s = ts_m;
    tick = rt ? 1'($urandom) : 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL early_valid_cmp got=%b want=0", out_valid); end
    si = int'(hash[9:0]);
    hw = -1;
    for (int w = 0; w < 4; w++) if (hw < 0 && mv[si][w] && mk[si][w] === key) hw = w;
    e = '0;
    if (hw >= 0) begin
      a = ts_s - mt[si][hw];
      expd = a >= 16'd1000;
      e[4] = !expd;
      e[3] = expd;
      e[1:0] = ms[si][hw];
      if (set) begin
        e[1:0] = expd ? st : (st > ms[si][hw] ? st : ms[si][hw]);
        ms[si][hw] = e[1:0];
        mt[si][hw] = ts_s;
      end
    end else if (set) begin
      vic = -1;
      for (int w = 0; w < 4; w++) if (vic < 0 && !mv[si][w]) vic = w;
      for (int w = 0; w < 4; w++) if (vic < 0 && 16'(ts_s - mt[si][w]) >= 16'd1000) vic = w;
      if (vic < 0) begin
        e[2] = 1;
        best = 0;
        for (int w = 1; w < 4; w++) if (16'(ts_s - mt[si][w]) > 16'(ts_s - mt[si][best])) best = w;
        vic = best;
      end
      mv[si][vic] = 1; mk[si][vic] = key; ms[si][vic] = st; mt[si][vic] = ts_s;
      e[1:0] = st;
    end
    @(negedge clk);
    tick = 0;
    obs = {out_hit, out_expired, out_evict, out_state};
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL out_valid got=%b want=1", out_valid); end
    checks++;
    if (obs !== e) begin failures++; $display("FAIL result set=%0b key=%h got=%b want=%b", set, key, obs, e); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL strobe_len got=%b want=0", out_valid); end
  endtask
  task automatic test_reset();
    int n;
    rst = 1; in_valid = 1; in_op = 4'b0000; in_hash = 32'h1; in_key = 96'h1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({out_valid, out_hit, out_expired, out_evict, out_state, in_ready, busy_init} !== 8'b0000_0001) begin
      failures++; $display("FAIL reset_outputs got=%b want=00000001",
        {out_valid, out_hit, out_expired, out_evict, out_state, in_ready, busy_init});
    end
    clear_model();
    rst = 0;
    flush_wait(n);
    checks++;
    if (n !== 1024) begin failures++; $display("FAIL flush_len got=%0d want=1024", n); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL ready_after_flush got=%b want=1", in_ready); end
    in_valid = 0;
  endtask
  task automatic test_set_get();
    logic [4:0] o;
    advance(5);
    req(1, 2'b01, 32'h0000_0100, 96'hA, 0, o);
    req(0, 2'b00, 32'h0000_0100, 96'hA, 0, o);
    checks++;
    if (o !== 5'b10001) begin failures++; $display("FAIL get_suspect got=%b want=10001", o); end
  endtask
  task automatic test_escalate();
    logic [4:0] o;
    req(1, 2'b10, 32'h0000_0100, 96'hA, 0, o);
    req(1, 2'b01, 32'h0000_0100, 96'hA, 0, o);
    checks++;
    if (o !== 5'b10010) begin failures++; $display("FAIL no_downgrade got=%b want=10010", o); end
    advance(1000);
    req(0, 2'b00, 32'h0000_0100, 96'hA, 0, o);
    checks++;
    if (o !== 5'b01010) begin failures++; $display("FAIL get_expired got=%b want=01010", o); end
  endtask
  task automatic test_evict();
    logic [4:0] o;
    for (int i = 0; i < 5; i++) begin
      req(1, 2'b01, 32'hBEEF_002A, 96'hB00 + 96'(i), 0, o);
      advance(1);
    end
    checks++;
    if (o !== 5'b00101) begin failures++; $display("FAIL evict_flag got=%b want=00101", o); end
    req(0, 2'b00, 32'h0000_002A, 96'hB00, 0, o);
    checks++;
    if (o !== 5'b00000) begin failures++; $display("FAIL evicted_miss got=%b want=00000", o); end
    req(0, 2'b00, 32'h0000_002A, 96'hB04, 0, o);
    checks++;
    if (o !== 5'b10001) begin failures++; $display("FAIL newest_hit got=%b want=10001", o); end
  endtask
  task automatic test_random();
    logic [4:0] o;
    for (int i = 0; i < 150; i++) begin
      req(1'($urandom), 2'($urandom), {22'($urandom), $urandom_range(0, 1) ? 10'd7 : 10'd8},
          96'hC000 + 96'($urandom_range(0, 7)), 1, o);
      advance($urandom_range(0, 9) == 0 ? 500 : $urandom_range(0, 3));
    end
  endtask
  task automatic test_rst_write();
    int n;
    logic [4:0] o;
    in_valid = 1; in_op = 4'b0011; in_hash = 32'h55; in_key = 96'hD00D;
    n = 0;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_write_valid got=%b want=0", out_valid); end
    @(negedge clk);
    rst = 0;
    clear_model();
    flush_wait(n);
    checks++;
    if (n !== 1024) begin failures++; $display("FAIL reflush_len got=%0d want=1024", n); end
    req(0, 2'b00, 32'h55, 96'hD00D, 0, o);
    checks++;
    if (o !== 5'b00000) begin failures++; $display("FAIL aborted_set_miss got=%b want=00000", o); end
  endtask
  task automatic test_wrap();
    logic [4:0] o;
    advance(65530);
    req(1, 2'b01, 32'h77, 96'hE0E0, 0, o);
    advance(10);
    req(0, 2'b00, 32'h77, 96'hE0E0, 0, o);
    checks++;
    if (o !== 5'b10001) begin failures++; $display("FAIL wrap_hit got=%b want=10001", o); end
  endtask
  initial begin
    test_reset();
    test_set_get();
    test_escalate();
    test_evict();
    test_random();
    test_rst_write();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/db_cont_nway.md
Name: db_cont_nway

Overview:
- Parametrised successor of the single-way flow-state table controller: a WAYS-way set-associative key/state table with per-entry timestamp expiry.
- Adds a ready/valid request handshake, post-reset table flush, replacement on miss, and state-escalation rules.
- Sits between the packet parser (hash/key/op producer) and the filter action stage.

Parameters:
HASH_SIZE, 32, width of in_hash; low RAM_ADDR bits select the set
KEY_SIZE, 96, key width
RAM_ADDR, 10, set-index width (2^RAM_ADDR sets)
WAYS, 4, ways per set (1..8)
TS_W, 16, timestamp/counter width
TTL, 1000, entry lifetime in tick units (< 2^(TS_W-1))

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
tick  in  1  one-cycle pulse that advances the timestamp counter
in_valid  in  1  request valid
in_ready  out  1  controller can accept a request
in_op  in  4  [0]=SET(1)/GET(0); [2:1]=requested state for SET; [3] reserved, ignored
in_hash  in  HASH_SIZE  precomputed hash
in_key  in  KEY_SIZE  lookup key
out_valid  out  1  one-cycle result strobe
out_hit  out  1  key present and not expired
out_expired  out  1  key present but expired
out_state  out  2  entry state after the operation (00 IDLE, 01 SUSPECT, 10 ARREST, 11 EXPIRE)
out_evict  out  1  SET miss overwrote a valid, unexpired entry
busy_init  out  1  flush in progress

Behaviour:
- Entry fields: valid(1), key, state(2), ts(TS_W). Stored in WAYS single-port RAMs, depth 2^RAM_ADDR, 1-cycle registered read.
- Reset: all outputs 0 except busy_init=1. ts_cnt=0. FSM enters INIT. rst mid-operation aborts any request with no write and no out_valid, then re-flushes.
- Timestamp counter: ts_cnt increments on tick and wraps modulo 2^TS_W.
- Entry age: age = (ts_cnt - entry.ts) mod 2^TS_W. Entry is expired when age >= TTL. ts_cnt is sampled in CMP.
- FSM states: INIT, IDLE, READ, CMP, WRITE.
  - INIT: writes valid=0 to set index 0..2^RAM_ADDR-1 across all ways, one index per cycle. After the last index, goes to IDLE and busy_init falls the same cycle.
  - IDLE: in_ready=1 only in this state. On in_valid&in_ready, latch op/key/set index and go to READ.
  - READ: present the set index to all ways. Go to CMP.
  - CMP: compare all ways in parallel. Hit way = lowest-index valid way with a key match. GET goes to IDLE; SET goes to WRITE.
  - WRITE: write one way. Go to IDLE.
- Latency: out_valid is high exactly one cycle, the cycle after CMP, i.e. the 3rd cycle after acceptance. Throughput: 1 GET per 3 cycles, 1 SET per 4 cycles.
- GET:
  - Hit, not expired: out_hit=1, out_state=stored state.
  - Hit, expired: out_expired=1, out_state=stored state. No write.
  - Miss: all result flags 0, out_state=00.
- SET hit: write the hit way with ts=ts_cnt.
  - Not expired: state=max(stored, requested), except a stored ARREST is never lowered. Requested EXPIRE forces 11.
  - Expired: state=requested.
  - out_hit/out_expired as for GET. out_state = written state.
- SET miss: victim = lowest-index invalid way; else lowest-index expired way; else the way with maximal age, ties to the lowest index. out_evict=1 only in the last case. Write valid=1, key, requested state, ts=ts_cnt. out_state = requested state.
- A tick arriving in the same cycle as CMP is counted after sampling, so the written ts uses the pre-increment value.
- Requests are never dropped. The upstream holds in_valid/in_op/in_hash/in_key until accepted.

Decomposition:
- Package db_pkg: OP_SET/OP_GET bit constants, state encodings (ST_IDLE/SUSPECT/ARREST/EXPIRE), FSM state enum, entry struct/field widths.
- Sub-module db_way_ram: single-port, sync-read, write-first RAM holding one way's {valid,state,ts,key}. Instantiated WAYS times via generate.
- Victim-select and compare logic stays in db_cont_nway.

Test Plan:
1. Reset, then hold in_valid=1 -> in_ready=0 and busy_init=1 for exactly 1024 cycles; first acceptance on cycle 1025.
2. SET key A, op=0011 (SUSPECT), ts_cnt=5; then GET A -> out_valid 3 cycles after acceptance, out_hit=1, out_state=01.
3. SET A ARREST, then SET A op=0011 before expiry -> out_state=10 (no downgrade). Advance 1000 ticks, then GET A -> out_expired=1, out_hit=0.
4. WAYS=4: SET five distinct keys to one set index at ts 0,1,2,3,4 -> 5th SET gives out_evict=1 and replaces way 0. GET of the first key misses.
5. ts_cnt wrap: entry written at ts=65530, GET after 10 ticks (ts_cnt=4) -> age 10, not expired, out_hit=1.
6. Assert rst in the WRITE cycle -> no out_valid; after the flush, GET of that key misses.
